// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, its IRAM port and the decode stage.
// The master side is the fetch unit; the slave side is the IRAM/decode environment.
interface instr_fetch_unit_if;
    logic [1:0]  iram_control;
    logic [15:0] iram_addr;
    logic [15:0] iram_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_word;
    logic [3:0]  instr_opcode;
    logic [15:0] instr_imm;
    logic [15:0] instr_pc;
    logic        branch_en;
    logic [15:0] branch_target;

    modport master (
        output iram_control, iram_addr, instr_valid, instr_word,
               instr_opcode, instr_imm, instr_pc,
        input  iram_data, instr_ready, branch_en, branch_target
    );

    modport slave (
        input  iram_control, iram_addr, instr_valid, instr_word,
               instr_opcode, instr_imm, instr_pc,
        output iram_data, instr_ready, branch_en, branch_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch front-end: reads an opcode word (plus an immediate word for LOAD/JMPZ)
// from one IRAM port, presents the bundle to decode over valid/ready, follows
// redirects on the handshake and parks in HALT once END has been accepted.
// All outputs come straight from flops; their next values are computed from
// the next FSM state so each one lines up with the state it belongs to.
module instr_fetch_unit #(
    parameter logic [15:0] START_ADDR = 16'd0,
    parameter int unsigned MEM_DEPTH  = 64,
    parameter logic [1:0]  READ_CODE  = 2'd1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    instr_fetch_unit_if.master bus,
    output logic               busy,
    output logic               halted
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_CAP     = 3'd2,
        S_IMM_REQ = 3'd3,
        S_IMM_CAP = 3'd4,
        S_HOLD    = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(MEM_DEPTH);
    localparam logic [3:0]  OP_END  = 4'd1;
    localparam logic [3:0]  OP_LOAD = 4'd4;
    localparam logic [3:0]  OP_JMPZ = 4'd15;

    // Add a small increment to an in-range PC, wrapping at MEM_DEPTH.
    function automatic logic [15:0] pc_advance(input logic [15:0] base, input logic [15:0] inc);
        logic [15:0] res;
        if (base >= DEPTH_W - inc) begin
            res = base + inc - DEPTH_W;
        end else begin
            res = base + inc;
        end
        return res;
    endfunction

    // Only LOAD and JMPZ carry an immediate in the following word.
    function automatic logic is_two_word(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_JMPZ);
    endfunction

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [15:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [15:0] word_q, word_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [15:0] imm_q, imm_d;
    logic [15:0] ipc_q, ipc_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;
    logic        armed_q;
    logic        hand_s;
    logic [15:0] len_s;
    logic [15:0] redirect_s;

    // Next-state, PC and registered-output computation for the fetch FSM.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ctrl_d     = 2'd0;
        addr_d     = addr_q;
        valid_d    = 1'b0;
        word_d     = word_q;
        opcode_d   = opcode_q;
        imm_d      = imm_q;
        ipc_d      = ipc_q;
        busy_d     = 1'b0;
        halted_d   = halted_q;
        hand_s     = (state_q == S_HOLD) && bus.instr_ready;
        len_s      = is_two_word(opcode_q) ? 16'd2 : 16'd1;
        redirect_s = bus.branch_target % DEPTH_W;

        case (state_q)
            S_IDLE, S_HALT: begin
                // armed_q masks a start that coincides with reset release
                if (start && armed_q) begin
                    state_d  = S_REQ;
                    pc_d     = START_ADDR;
                    halted_d = 1'b0;
                end else begin
                    state_d  = state_q;
                end
            end
            S_REQ: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                word_d   = bus.iram_data;
                opcode_d = bus.iram_data[13:10];
                ipc_d    = pc_q;
                imm_d    = 16'd0;
                if (is_two_word(bus.iram_data[13:10])) begin
                    state_d = S_IMM_REQ;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_IMM_REQ: begin
                state_d = S_IMM_CAP;
            end
            S_IMM_CAP: begin
                imm_d   = bus.iram_data;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (hand_s) begin
                    if (opcode_q == OP_END) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d  = S_REQ;
                    end
                    if (bus.branch_en) begin
                        pc_d = redirect_s;
                    end else begin
                        pc_d = pc_advance(pc_q, len_s);
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Address is only updated when a read is issued, so it stays stable otherwise.
        if (state_d == S_REQ) begin
            ctrl_d = READ_CODE;
            addr_d = pc_d;
        end else if (state_d == S_IMM_REQ) begin
            ctrl_d = READ_CODE;
            addr_d = pc_advance(pc_q, 16'd1);
        end else begin
            ctrl_d = 2'd0;
            addr_d = addr_q;
        end
        valid_d = (state_d == S_HOLD);
        busy_d  = (state_d != S_IDLE) && (state_d != S_HALT);
    end

    // State, PC, bundle and output registers; reset clears every output at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            pc_q     <= START_ADDR;
            ctrl_q   <= 2'd0;
            addr_q   <= 16'd0;
            valid_q  <= 1'b0;
            word_q   <= 16'd0;
            opcode_q <= 4'd0;
            imm_q    <= 16'd0;
            ipc_q    <= 16'd0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ctrl_q   <= ctrl_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            word_q   <= word_d;
            opcode_q <= opcode_d;
            imm_q    <= imm_d;
            ipc_q    <= ipc_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            armed_q  <= 1'b1;
        end
    end

    assign bus.iram_control = ctrl_q;
    assign bus.iram_addr    = addr_q;
    assign bus.instr_valid  = valid_q;
    assign bus.instr_word   = word_q;
    assign bus.instr_opcode = opcode_q;
    assign bus.instr_imm    = imm_q;
    assign bus.instr_pc     = ipc_q;
    assign busy             = busy_q;
    assign halted           = halted_q;
endmodule
